// File: rtl/des_arb.sv
// des_arb: two-channel round-robin arbiter and sequencer for a shared
// iterative DES datapath core. A channel hands over one 64-bit block per
// valid/ready handshake. The block goes to the core with a one-cycle start
// pulse. When the core answers, the result is routed back to the channel
// that owns the block.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_chN_valid/o_chN_ready/i_chN_data/i_chN_flag   channel N request
//                         (flag 1 = encrypt, 0 = decrypt)
//   o_chN_dout/o_chN_dout_en   channel N result and 1-cycle strobe
//   o_core_din/o_core_din_en/o_core_flag   block, start pulse and mode to
//                         the core (mode held from issue to next issue)
//   i_core_dout/i_core_dout_en   core result and strobe
//   o_busy                high while a block is in flight (ISSUE/BUSY)
//   o_err                 1-cycle pulse on core timeout or spurious result
//
// Optional build macro DES_ARB_STAT_EN adds o_ch0_cnt/o_ch1_cnt, which are
// 16-bit wrapping counters of completed blocks per channel.

module des_arb_lane (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [63:0] i_data,
  output logic [63:0] o_dout,
  output logic        o_dout_en
`ifdef DES_ARB_STAT_EN
  ,
  output logic [15:0] o_cnt
`endif
);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dout    <= '0;
      o_dout_en <= 1'b0;
    end else begin
      o_dout_en <= i_load;
      if (i_load) o_dout <= i_data;
    end
  end

`ifdef DES_ARB_STAT_EN
  // The counter is bumped together with the strobe, so both change on the
  // same edge. Natural 16-bit overflow supplies the wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst)       o_cnt <= '0;
    else if (i_load) o_cnt <= o_cnt + 16'd1;
  end
`endif
endmodule

module des_arb #(
  parameter int TIMEOUT = 20,
  parameter int CW      = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ch0_valid,
  output logic        o_ch0_ready,
  input  logic [63:0] i_ch0_data,
  input  logic        i_ch0_flag,
  output logic [63:0] o_ch0_dout,
  output logic        o_ch0_dout_en,
  input  logic        i_ch1_valid,
  output logic        o_ch1_ready,
  input  logic [63:0] i_ch1_data,
  input  logic        i_ch1_flag,
  output logic [63:0] o_ch1_dout,
  output logic        o_ch1_dout_en,
  output logic [63:0] o_core_din,
  output logic        o_core_din_en,
  output logic        o_core_flag,
  input  logic [63:0] i_core_dout,
  input  logic        i_core_dout_en,
  output logic        o_busy,
  output logic        o_err
`ifdef DES_ARB_STAT_EN
  ,
  output logic [15:0] o_ch0_cnt,
  output logic [15:0] o_ch1_cnt
`endif
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  typedef struct packed {
    logic [63:0] data;
    logic        flag;
  } req_t;

  state_t                       state;
  logic                         r_last;   // channel granted most recently
  logic                         owner;    // channel owning the in-flight block
  logic [CW-1:0]                cnt;
  req_t [NUM_LANES-1:0]         req;
  logic [NUM_LANES-1:0]         req_vld;
  logic                         gnt_any;
  logic                         gnt_ch;
  logic                         core_done;
  logic [NUM_LANES-1:0]         rsp_load;
  logic [NUM_LANES-1:0][63:0]   lane_dout;
  logic [NUM_LANES-1:0]         lane_dout_en;

  assign req[0]  = '{data: i_ch0_data, flag: i_ch0_flag};
  assign req[1]  = '{data: i_ch1_data, flag: i_ch1_flag};
  assign req_vld = {i_ch1_valid, i_ch0_valid};

  // Round-robin on a tie. r_last resets to 1, so channel 0 wins the first tie.
  always_comb begin
    gnt_any = |req_vld;
    gnt_ch  = 1'b0;
    if (&req_vld) gnt_ch = ~r_last;
    else          gnt_ch = req_vld[1];
  end

  assign o_ch0_ready = (state == IDLE) && gnt_any && !gnt_ch;
  assign o_ch1_ready = (state == IDLE) && gnt_any &&  gnt_ch;

  // A result is accepted only while BUSY. A strobe in IDLE/ISSUE is an error.
  assign core_done = (state == BUSY) && i_core_dout_en;
  assign rsp_load  = {core_done & owner, core_done & ~owner};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      r_last        <= 1'b1;
      owner         <= 1'b0;
      cnt           <= '0;
      o_core_din    <= '0;
      o_core_din_en <= 1'b0;
      o_core_flag   <= 1'b1;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_core_din_en <= 1'b0;
      o_err         <= 1'b0;
      case (state)
        IDLE: begin
          if (i_core_dout_en) o_err <= 1'b1;
          if (gnt_any) begin
            // The start pulse is raised here, so it is high exactly during ISSUE.
            o_core_din    <= req[gnt_ch].data;
            o_core_flag   <= req[gnt_ch].flag;
            owner         <= gnt_ch;
            r_last        <= gnt_ch;
            o_core_din_en <= 1'b1;
            o_busy        <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_core_dout_en) o_err <= 1'b1;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // A result on the last allowed cycle still wins over the timeout.
          if (i_core_dout_en) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            o_err  <= 1'b1;
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef DES_ARB_STAT_EN
  logic [NUM_LANES-1:0][15:0] lane_cnt;
  assign o_ch0_cnt = lane_cnt[0];
  assign o_ch1_cnt = lane_cnt[1];
`endif

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    des_arb_lane u_lane (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (rsp_load[n]),
      .i_data    (i_core_dout),
      .o_dout    (lane_dout[n]),
      .o_dout_en (lane_dout_en[n])
`ifdef DES_ARB_STAT_EN
      ,
      .o_cnt     (lane_cnt[n])
`endif
    );
  end

  assign o_ch0_dout    = lane_dout[0];
  assign o_ch0_dout_en = lane_dout_en[0];
  assign o_ch1_dout    = lane_dout[1];
  assign o_ch1_dout_en = lane_dout_en[1];
endmodule

// File: doc/des_arb.md
Name: des_arb

Overview:
- Two-channel round-robin arbiter and sequencer that shares one iterative DES datapath core (des_dpc) between two requesters.
- Accepts one 64-bit block per handshake and issues it to the core as a single-cycle start pulse.
- Holds the encrypt/decrypt flag stable for the whole 16-round operation, then routes the core result back to the owning channel.
- Guarantees the core never receives a new start while busy, and flags a core that never finishes or produces a spurious result.

Parameters:
- TIMEOUT, 20, BUSY cycles allowed before the core result is declared lost (must be > 16, < 32)
- CW, 5, width of the BUSY cycle counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_ch0_valid  in  1  channel 0 block request
- o_ch0_ready  out  1  channel 0 block accepted this cycle when valid&ready
- i_ch0_data  in  64  channel 0 input block
- i_ch0_flag  in  1  channel 0 mode: 1 encrypt, 0 decrypt
- o_ch0_dout  out  64  channel 0 result block
- o_ch0_dout_en  out  1  channel 0 result strobe, 1 cycle, no backpressure
- i_ch1_valid, o_ch1_ready, i_ch1_data, i_ch1_flag, o_ch1_dout, o_ch1_dout_en: same as channel 0, for channel 1
- o_core_din  out  64  block to core
- o_core_din_en  out  1  core start pulse
- o_core_flag  out  1  core mode, held from issue until next issue
- i_core_dout  in  64  core result
- i_core_dout_en  in  1  core result strobe (15 cycles after start)
- o_busy  out  1  high in ISSUE/BUSY
- o_err  out  1  1-cycle pulse on timeout or spurious core result

Behaviour:
- Reset values:
  - all strobes, o_err and o_busy = 0
  - o_core_din = 0, o_core_flag = 1
  - all o_chN_dout = 0
  - state = IDLE, r_last = 1 (so channel 0 wins the first tie), counter = 0
- Reset mid-operation: return to IDLE and drop the in-flight block; no response and no o_err.
- Grant (combinational, IDLE only):
  - exactly one valid: grant that channel
  - both valid: grant channel != r_last
  - o_chN_ready = (state==IDLE) && grant==N; ready is never high outside IDLE.
- Handshake cycle T (valid&ready):
  - register data into o_core_din and flag into o_core_flag
  - set owner = N and r_last = N
  - go to ISSUE.
- ISSUE (T+1): o_core_din_en = 1 for exactly 1 cycle; clear counter; go to BUSY.
- BUSY: counter increments each cycle.
  - On i_core_dout_en: register i_core_dout into o_<owner>_dout; pulse o_<owner>_dout_en at the next cycle; go to IDLE.
  - Other channel's dout/dout_en unchanged.
  - If counter reaches TIMEOUT-1 with no i_core_dout_en: pulse o_err, go to IDLE, no channel response. i_core_dout_en on that same cycle wins (normal completion, no error).
- Nominal timing (core latency 15):
  - handshake T, core start T+1, core result T+16
  - channel strobe T+17; IDLE at T+17, so the next handshake can occur at T+17
  - throughput 1 block per 17 cycles.
- i_core_dout_en in IDLE or ISSUE: ignored for routing; o_err pulses next cycle.
- A requester may drop valid before ready without effect; data/flag sampled only at handshake.
- o_core_flag stays constant from T+1 through the result, then holds until the next handshake.

Optional Feature:
- Macro DES_ARB_STAT_EN.
- When defined:
  - adds outputs o_ch0_cnt[15:0] and o_ch1_cnt[15:0]: completed-block counters
  - a counter increments on the cycle its o_chN_dout_en pulses
  - wraps 16'hFFFF -> 0; reset to 0
  - timeouts are not counted.
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Real des_dpc with key 133457799BBCDFF1 expanded; ch0 valid, data 0123456789ABCDEF, flag 1 at T -> o_core_din_en at T+1; o_ch0_dout = 85E813540F0AB405 with o_ch0_dout_en at T+17; o_ch1_dout_en stays 0.
- ch1 decrypt 85E813540F0AB405 -> o_ch1_dout = 0123456789ABCDEF; o_core_flag = 0 from T+1 to result.
- ch0 and ch1 valid continuously from reset -> grants alternate 0,1,0,1; handshakes 17 cycles apart; ready never high while o_busy = 1.
- Stub core never asserts i_core_dout_en -> o_err pulse 20 cycles after start; no dout_en; next request accepted afterwards.
- i_core_dout_en pulsed in IDLE -> o_err 1 cycle, no channel strobe; i_rst asserted at T+8 -> IDLE, no response, no o_err.
- DES_ARB_STAT_EN defined: 3 ch0 and 2 ch1 completions -> o_ch0_cnt = 3, o_ch1_cnt = 2; preload-equivalent run of 65536 ch0 blocks -> o_ch0_cnt wraps to 0.
